input_debouncer4: RTL and testbench

Input conditioning stage for the four-input logic exercise. It synchronises four raw switch/button lines to `clk`, debounces each one independently, and drives the stable `a`, `b`, `c` and `d` levels into the combinational function block downstream. It also produces a one-cycle change strobe, so a downstream consumer registers `x` only when an input has actually changed.

---
 rtl/input_debouncer4_pkg.sv | 15 +
 rtl/input_debouncer4_debounce_bit.sv | 54 +++++
 rtl/input_debouncer4.sv | 61 ++++++
 tb/tb_input_debouncer4.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/input_debouncer4_pkg.sv
// Shared constants for the four-input debouncer: default timing and the
// sw_in bit positions of the a..d channels.
package input_debouncer4_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  localparam int NUM_CH = 4;

  localparam int IDX_A = 3;
  localparam int IDX_B = 2;
  localparam int IDX_C = 1;
  localparam int IDX_D = 0;

endpackage

// File: rtl/input_debouncer4_debounce_bit.sv
// One debounce channel: synchroniser chain, persistence counter and the
// accepted level, plus a combinational accept pulse for the edge that commits it.
module debounce_bit
  import input_debouncer4_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic accept
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt;
  logic                   stable_q;

  // Synchroniser: only sync_p[0] may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_out = sync_p[SYNC_STAGES-1];

  // Any return to the accepted level clears the count; the terminal
  // compare both commits the new level and keeps cnt from wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else if (sync_out == stable_q) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable_q <= sync_out;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign accept = (sync_out != stable_q) && (cnt == CNT_MAX);
  assign stable = stable_q;

endmodule

// File: rtl/input_debouncer4.sv
// Four-channel input debouncer feeding a, b, c, d. The change strobe is built
// only when CHANGE_STROBE_EN is defined; otherwise change_stb is constant 0.
module input_debouncer4
  import input_debouncer4_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       change_stb
);

  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] accept;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (sw_in[i]),
      .stable (stable[i]),
      .accept (accept[i])
    );
  end

  assign a = stable[IDX_A];
  assign b = stable[IDX_B];
  assign c = stable[IDX_C];
  assign d = stable[IDX_D];

`ifdef CHANGE_STROBE_EN
  logic change_stb_q;

  // Registered on the same edge that updates stable, so the strobe is
  // aligned with the first cycle of the new levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_stb_q <= 1'b0;
    end else begin
      change_stb_q <= |accept;
    end
  end

  assign change_stb = change_stb_q;
`else
  logic unused_accept;

  assign unused_accept = |accept;
  assign change_stb    = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer4.sv
// Directed bench for input_debouncer4 with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// (acceptance on the 6th edge after a change); strobe expectations follow CHANGE_STROBE_EN.
module tb_input_debouncer4;

`ifdef CHANGE_STROBE_EN
  localparam bit STB_EN = 1'b1;
`else
  localparam bit STB_EN = 1'b0;
`endif
  localparam int LAT = 6;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic       a, b, c, d;
  logic       change_stb;

  int checks   = 0;
  int failures = 0;
  int stb_seen = 0;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] exp_out;
    logic       exp_stb;
  } vec_t;

  vec_t tbl [17];

  input_debouncer4 #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .change_stb (change_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Apply sw and check outputs/strobe on each of the next nedges edges.
  task automatic window(input string name, input logic [3:0] sw,
                        input logic [3:0] prev_out, input logic [3:0] exp_out,
                        input logic exp_change, input int nedges);
    logic [3:0] e_out;
    logic       e_stb;
    sw_in = sw;
    for (int e = 1; e <= nedges; e++) begin
      tick();
      e_out = (e >= LAT) ? exp_out : prev_out;
      e_stb = STB_EN && exp_change && (e == LAT);
      if (change_stb) stb_seen++;
      chk({name, "_out"}, {a, b, c, d}, e_out);
      chk({name, "_stb"}, {3'b000, change_stb}, {3'b000, e_stb});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].sw      = i[3:0];
      tbl[i].exp_out = i[3:0];
      tbl[i].exp_stb = (i != 0);
    end
    tbl[16].sw      = 4'b0000;
    tbl[16].exp_out = 4'b0000;
    tbl[16].exp_stb = 1'b1;

    // Reset held with all inputs high.
    rst_n = 1'b0;
    sw_in = 4'b1111;
    repeat (3) tick();
    chk("reset_out", {a, b, c, d}, 4'b0000);
    chk("reset_stb", {3'b000, change_stb}, 4'b0000);
    rst_n = 1'b1;
    window("reset_release", 4'b1111, 4'b0000, 4'b1111, 1'b1, 8);

    // Asynchronous clear mid-cycle, no clock edge involved.
    #2 rst_n = 1'b0;
    #1 chk("async_clear_out", {a, b, c, d}, 4'b0000);
    chk("async_clear_stb", {3'b000, change_stb}, 4'b0000);
    repeat (2) tick();
    sw_in = 4'b0000;
    rst_n = 1'b1;
    repeat (3) tick();

    window("clean", 4'b0100, 4'b0000, 4'b0100, 1'b1, 9);
    window("clean_back", 4'b0000, 4'b0100, 4'b0000, 1'b1, 8);

    // Glitch of 3 cycles on sw_in[0] must be rejected.
    sw_in = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) sw_in = 4'b0000;
      tick();
      chk("glitch3_out", {a, b, c, d}, 4'b0000);
      chk("glitch3_stb", {3'b000, change_stb}, 4'b0000);
    end

    // 4-cycle pulse: accepted at E6, released again at E10.
    sw_in = 4'b0001;
    for (int e = 1; e <= 14; e++) begin
      if (e == 5) sw_in = 4'b0000;
      tick();
      chk("pulse4_out", {a, b, c, d}, {3'b000, (e >= 6 && e < 10)});
      chk("pulse4_stb", {3'b000, change_stb}, {3'b000, STB_EN && (e == 6 || e == 10)});
    end

    window("simul", 4'b1011, 4'b0000, 4'b1011, 1'b1, 8);
    window("simul_back", 4'b0000, 4'b1011, 4'b0000, 1'b1, 8);

    // Reset while the count is at 2, then fresh acceptance.
    sw_in = 4'b1111;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("midcount_pre", {a, b, c, d}, 4'b0000);
    end
    #2 rst_n = 1'b0;
    #1 chk("midcount_rst_out", {a, b, c, d}, 4'b0000);
    chk("midcount_rst_stb", {3'b000, change_stb}, 4'b0000);
    repeat (2) tick();
    rst_n = 1'b1;
    window("midcount_fresh", 4'b1111, 4'b0000, 4'b1111, 1'b1, 8);
    window("midcount_back", 4'b0000, 4'b1111, 4'b0000, 1'b1, 8);

    // Sweep 0..15 and back to 0, 8 cycles per value.
    stb_seen = 0;
    for (int i = 0; i < 17; i++) begin
      window("sweep", tbl[i].sw, (i == 0) ? 4'b0000 : tbl[i-1].exp_out,
             tbl[i].exp_out, tbl[i].exp_stb, 8);
    end
    checks++;
    if (stb_seen != (STB_EN ? 16 : 0)) begin
      failures++;
      $display("FAIL sweep_strobe_count actual=%0d required=%0d", stb_seen, STB_EN ? 16 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
